// File: rtl/bitbang_cfg_serializer.sv
// Serialises configuration words onto the fabric s_clk/s_data pins: each data bit
// is followed by one control-word bit, and each bit pair is framed by one s_clk pulse.
module bitbang_cfg_serializer #(
    parameter int                LANES        = 1,
    parameter int                WORD_W       = 32,
    parameter logic [WORD_W-1:0] CTRL_WORD    = 'h0000FAB1,
    parameter int                PHASE_CYCLES = 1,
    parameter int                CNT_W        = 16
) (
    input  logic                    CLK,
    input  logic                    resetn,
    input  logic [LANES*WORD_W-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    s_clk,
    output logic [LANES-1:0]        s_data,
    output logic                    busy,
    output logic [CNT_W-1:0]        words_sent
);

    localparam int PH_W = $clog2(2 * PHASE_CYCLES);
    localparam int J_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PHASE_CYCLES - 1);
    localparam logic [PH_W-1:0] PHD_LAST = PH_W'(2 * PHASE_CYCLES - 1);
    localparam logic [J_W-1:0]  J_LAST   = J_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        PH_A,
        PH_B,
        PH_C,
        PH_D
    } state_t;

    state_t                  state, state_n;
    logic [PH_W-1:0]         ph_cnt, ph_n;
    logic [J_W-1:0]          bit_idx, idx_n;
    logic [LANES*WORD_W-1:0] shreg, sh_n;
    logic [WORD_W-1:0]       ctrl_sh, ctrl_n;
    logic [CNT_W-1:0]        cnt_n;
    logic                    load;
    logic                    s_clk_n, busy_n, ready_n;
    logic [LANES-1:0]        s_data_n, lane_msb;

    // Next-state logic. The shift registers move one bit per completed PH_D, so the
    // current data bit of every lane is always its MSB. Shifting the whole vector lets
    // a lane's MSB leak into the next lane's LSB, but those bits are never reached
    // before the next load.
    always_comb begin
        state_n = state;
        ph_n    = ph_cnt;
        idx_n   = bit_idx;
        sh_n    = shreg;
        ctrl_n  = ctrl_sh;
        cnt_n   = words_sent;
        load    = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                end
            end
            PH_A: begin
                if (ph_cnt == PH_LAST) begin
                    state_n = PH_B;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_cnt + 1'b1;
                end
            end
            PH_B: begin
                if (ph_cnt == PH_LAST) begin
                    state_n = PH_C;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_cnt + 1'b1;
                end
            end
            PH_C: begin
                if (ph_cnt == PH_LAST) begin
                    state_n = PH_D;
                    ph_n    = '0;
                end else begin
                    ph_n = ph_cnt + 1'b1;
                end
            end
            PH_D: begin
                if (ph_cnt == PHD_LAST) begin
                    if (bit_idx != J_LAST) begin
                        state_n = PH_A;
                        ph_n    = '0;
                        idx_n   = bit_idx + 1'b1;
                        sh_n    = shreg << 1;
                        ctrl_n  = ctrl_sh << 1;
                    end else begin
                        cnt_n = words_sent + 1'b1;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                            ph_n    = '0;
                        end
                    end
                end else begin
                    ph_n = ph_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                ph_n    = '0;
            end
        endcase

        if (load) begin
            state_n = PH_A;
            ph_n    = '0;
            idx_n   = '0;
            sh_n    = in_data;
            ctrl_n  = CTRL_WORD;
        end
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        lane_msb = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_msb[k] = sh_n[k*WORD_W + WORD_W - 1];
        end

        s_clk_n  = (state_n == PH_B) || (state_n == PH_C);
        busy_n   = (state_n != IDLE);
        ready_n  = (state_n == IDLE) ||
                   ((state_n == PH_D) && (ph_n == PHD_LAST) && (idx_n == J_LAST));
        s_data_n = '0;
        case (state_n)
            PH_A, PH_B: s_data_n = lane_msb;
            PH_C, PH_D: s_data_n = {LANES{ctrl_n[WORD_W-1]}};
            default:    s_data_n = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state      <= IDLE;
            ph_cnt     <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            ctrl_sh    <= '0;
            words_sent <= '0;
            s_clk      <= 1'b0;
            s_data     <= '0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state      <= state_n;
            ph_cnt     <= ph_n;
            bit_idx    <= idx_n;
            shreg      <= sh_n;
            ctrl_sh    <= ctrl_n;
            words_sent <= cnt_n;
            s_clk      <= s_clk_n;
            s_data     <= s_data_n;
            busy       <= busy_n;
            in_ready   <= ready_n;
        end
    end

endmodule

// File: tb/tb_bitbang_cfg_serializer.sv
// Randomised bench for bitbang_cfg_serializer: two instances (1 lane / 1 cycle phases with
// a 2-bit counter, and 4 lanes / 3 cycle phases) checked every cycle against a word-level model.
module tb_bitbang_cfg_serializer;

    localparam int W      = 32;
    localparam int P1     = 1;
    localparam int P2     = 3;
    localparam int LAST1  = 5 * P1 * W - 1;
    localparam int LAST2  = 5 * P2 * W - 1;
    localparam logic [31:0] CTRL = 32'h0000FAB1;

    logic         clk = 1'b0;
    logic         resetn;
    logic [31:0]  in_data1;
    logic         in_valid1;
    logic         in_ready1, s_clk1, busy1;
    logic [0:0]   s_data1;
    logic [1:0]   words_sent1;
    logic [127:0] in_data2;
    logic         in_valid2;
    logic         in_ready2, s_clk2, busy2;
    logic [3:0]   s_data2;
    logic [15:0]  words_sent2;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int acc_cycle;
    bit chk_en   = 1'b0;

    // Word-level reference state: whether a word is in flight, cycle offset into it,
    // the word latched at accept and the number of completed words.
    bit           m1_act = 1'b0;
    int           m1_n   = 0;
    logic [127:0] m1_word = '0;
    int           m1_cnt = 0;
    bit           m2_act = 1'b0;
    int           m2_n   = 0;
    logic [127:0] m2_word = '0;
    int           m2_cnt = 0;

    bitbang_cfg_serializer #(
        .LANES(1), .WORD_W(W), .CTRL_WORD(CTRL), .PHASE_CYCLES(P1), .CNT_W(2)
    ) u1 (
        .CLK(clk), .resetn(resetn), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .s_clk(s_clk1), .s_data(s_data1), .busy(busy1),
        .words_sent(words_sent1)
    );

    bitbang_cfg_serializer #(
        .LANES(4), .WORD_W(W), .CTRL_WORD(CTRL), .PHASE_CYCLES(P2), .CNT_W(16)
    ) u2 (
        .CLK(clk), .resetn(resetn), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .s_clk(s_clk2), .s_data(s_data2), .busy(busy2),
        .words_sent(words_sent2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic exp_sclk(input int n, input int p);
        int ph = n % (5 * p);
        return (ph >= p) && (ph < 3 * p);
    endfunction

    function automatic logic [3:0] exp_sdata(input logic [127:0] word, input int n,
                                             input int p, input int lanes);
        int          j    = n / (5 * p);
        int          ph   = n % (5 * p);
        int          b    = W - 1 - j;
        logic [31:0] ctrl = CTRL;
        logic [3:0]  r    = '0;
        for (int k = 0; k < lanes; k++) begin
            r[k] = (ph < 2 * p) ? word[k*W + b] : ctrl[b];
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", tag, got, exp, cycle);
        end
    endtask

    // Model for instance 1.
    always @(posedge clk) begin
        if (!resetn) begin
            m1_act <= 1'b0;
            m1_n   <= 0;
            m1_cnt <= 0;
        end else if (in_valid1 && (!m1_act || m1_n == LAST1)) begin
            if (m1_act) m1_cnt <= m1_cnt + 1;
            m1_act  <= 1'b1;
            m1_n    <= 0;
            m1_word <= {96'h0, in_data1};
        end else if (m1_act) begin
            if (m1_n == LAST1) begin
                m1_cnt <= m1_cnt + 1;
                m1_act <= 1'b0;
            end else begin
                m1_n <= m1_n + 1;
            end
        end
    end

    // Model for instance 2.
    always @(posedge clk) begin
        if (!resetn) begin
            m2_act <= 1'b0;
            m2_n   <= 0;
            m2_cnt <= 0;
        end else if (in_valid2 && (!m2_act || m2_n == LAST2)) begin
            if (m2_act) m2_cnt <= m2_cnt + 1;
            m2_act  <= 1'b1;
            m2_n    <= 0;
            m2_word <= in_data2;
        end else if (m2_act) begin
            if (m2_n == LAST2) begin
                m2_cnt <= m2_cnt + 1;
                m2_act <= 1'b0;
            end else begin
                m2_n <= m2_n + 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("u1_sclk",  s_clk1, m1_act ? exp_sclk(m1_n, P1) : 1'b0);
            checkOutput("u1_sdata", {3'b0, s_data1},
                        m1_act ? exp_sdata(m1_word, m1_n, P1, 1) : 4'b0);
            checkOutput("u1_busy",  busy1, m1_act);
            checkOutput("u1_ready", in_ready1, !m1_act || (m1_n == LAST1));
            checkOutput("u1_cnt",   words_sent1, m1_cnt % 4);
            checkOutput("u2_sclk",  s_clk2, m2_act ? exp_sclk(m2_n, P2) : 1'b0);
            checkOutput("u2_sdata", s_data2,
                        m2_act ? exp_sdata(m2_word, m2_n, P2, 4) : 4'b0);
            checkOutput("u2_busy",  busy2, m2_act);
            checkOutput("u2_ready", in_ready2, !m2_act || (m2_n == LAST2));
            checkOutput("u2_cnt",   words_sent2, m2_cnt % 65536);
        end
    end

    function automatic logic rdy(input int sel);
        return (sel == 1) ? in_ready1 : in_ready2;
    endfunction

    // Called at a negedge; presents a word with in_valid high and returns at the negedge
    // after it is accepted. in_valid stays high. With toggle set, in_data is scrambled
    // every cycle while waiting, so whatever is present at accept is what gets sent.
    task automatic applyStimulus(input int sel, input logic [127:0] word, input bit toggle);
        int waited = 0;
        if (sel == 1) begin in_valid1 = 1'b1; in_data1 = word[31:0]; end
        else          begin in_valid2 = 1'b1; in_data2 = word;       end
        while (!rdy(sel) && waited < 3000) begin
            @(negedge clk);
            waited++;
            if (toggle) begin
                if (sel == 1) in_data1 = $urandom;
                else in_data2 = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        if (waited >= 3000) begin
            checkOutput("accept_timeout", 1'b0, 1'b1);
        end else begin
            acc_cycle = cycle;
            @(negedge clk);
        end
    endtask

    task automatic waitIdle(input int sel, output int busy_cycles);
        busy_cycles = 0;
        while (((sel == 1) ? busy1 : busy2) && busy_cycles < 5000) begin
            busy_cycles++;
            @(negedge clk);
        end
        if (busy_cycles >= 5000) checkOutput("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        int          t1, t2, nb;
        logic [31:0] w;
        resetn    = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        in_data1  = '0;
        in_data2  = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("reset_ready", in_ready1, 1'b1);
        checkOutput("reset_cnt", words_sent1, 2'd0);
        resetn = 1'b1;

        $display("[TB] single word 80000001");
        applyStimulus(1, 128'h80000001, 1'b0);
        in_valid1 = 1'b0;
        checkOutput("first_bit", s_data1, 1'b1);
        waitIdle(1, nb);
        checkOutput("busy_len", nb, 160);
        checkOutput("cnt_after_one", words_sent1, 2'd1);
        checkOutput("ready_after_one", in_ready1, 1'b1);

        $display("[TB] back-to-back words");
        applyStimulus(1, 128'hFFFFFFFF, 1'b0);
        t1 = acc_cycle;
        applyStimulus(1, 128'h00000000, 1'b0);
        t2 = acc_cycle;
        in_valid1 = 1'b0;
        checkOutput("b2b_gap", t2 - t1, 160);
        waitIdle(1, nb);
        checkOutput("cnt_after_three", words_sent1, 2'd3);

        $display("[TB] in_data toggling while busy");
        applyStimulus(1, {96'h0, $urandom}, 1'b0);
        applyStimulus(1, {96'h0, $urandom}, 1'b1);
        checkOutput("accept_at_end", t2 - t1, acc_cycle - t2 - (acc_cycle - t2 - 160));
        in_valid1 = 1'b0;
        waitIdle(1, nb);
        checkOutput("cnt_wrap", words_sent1, 2'd1);

        $display("[TB] reset mid-word");
        applyStimulus(1, {96'h0, $urandom}, 1'b0);
        in_valid1 = 1'b0;
        repeat (49) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checkOutput("rst_sclk", s_clk1, 1'b0);
        checkOutput("rst_sdata", s_data1, 1'b0);
        checkOutput("rst_busy", busy1, 1'b0);
        checkOutput("rst_cnt", words_sent1, 2'd0);
        checkOutput("rst_ready", in_ready1, 1'b1);
        w = 32'h7FFFFFFF;
        applyStimulus(1, {96'h0, w}, 1'b0);
        checkOutput("restart_bit0", s_data1, 1'b0);
        in_valid1 = 1'b0;
        waitIdle(1, nb);

        $display("[TB] random traffic");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, {96'h0, $urandom}, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                in_valid1 = 1'b0;
                repeat ($urandom_range(0, 200)) @(negedge clk);
            end
        end
        in_valid1 = 1'b0;
        waitIdle(1, nb);

        $display("[TB] four lanes, three-cycle phases");
        applyStimulus(2, {32'h0, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'h55555555}, 1'b0);
        in_valid2 = 1'b0;
        checkOutput("lanes_bit0", s_data2, 4'b0110);
        waitIdle(2, nb);
        checkOutput("busy_len_4l", nb, 480);
        checkOutput("cnt_4l", words_sent2, 16'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        end
        in_valid2 = 1'b0;
        waitIdle(2, nb);
        checkOutput("cnt_4l_end", words_sent2, 16'd4);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
